// File: rtl/prescale_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prescale_pkg : shared state type and defaults for prescale_detect  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package prescale_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam int unsigned LOCK_CNT_DEFAULT = 2;

endpackage
`default_nettype wire

// File: rtl/prescale_detect_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prescale_detect_if : measured clock, restart and decode results    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface prescale_detect_if #(
  parameter int N = 3
);
  logic         div_in;
  logic         clear;
  logic [N-1:0] prescale_out;
  logic         valid;
  logic         lock;
  logic         err;

  modport master (output div_in, clear, input prescale_out, valid, lock, err);
  modport slave  (input div_in, clear, output prescale_out, valid, lock, err);
endinterface
`default_nettype wire

// File: rtl/prescale_detect_sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_edge : optional 2-flop synchronizer + rising-edge pulse       |
// | Macro PRESCALE_DETECT_SYNC_EN inserts the synchronizer. Rev 1.0    |
// +--------------------------------------------------------------------+
module sync_edge (
  input  wire logic clk_in,
  input  wire logic rst_n,
  input  wire logic div_in,
  output logic      rise
);
  logic smp;
  logic prev_q, prev_d;

`ifdef PRESCALE_DETECT_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], div_in};
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign smp = sync_q[1];
`else
  assign smp = div_in;
`endif

  always_comb begin
    prev_d = smp;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = smp & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/prescale_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prescale_detect : measures a divided clock and decodes its index   |
// | Macro PRESCALE_DETECT_SYNC_EN selects the input sync. Rev 1.0      |
// +--------------------------------------------------------------------+
module prescale_detect
  import prescale_pkg::*;
#(
  parameter int N        = 3,
  parameter int LOCK_CNT = LOCK_CNT_DEFAULT
) (
  input wire logic          clk_in,
  input wire logic          rst_n,
  prescale_detect_if.slave  bus
);
  localparam int CW = 1 << N;
  localparam int SW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]   PER_ONE    = {{CW{1'b0}}, 1'b1};
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(LOCK_CNT);

  state_e        state_q, state_d;
  logic [CW-1:0] per_cnt_q, per_cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [N-1:0]  prescale_q, prescale_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          lock_q, lock_d;

  logic          rise;
  logic [CW:0]   period;
  logic          onehot;
  logic          dec_ok;
  logic [N-1:0]  dec_idx;
  logic [SW-1:0] streak_inc;

  sync_edge u_sync_edge (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .div_in (bus.div_in),
    .rise   (rise)
  );

  // per_cnt restarts at 0 on the edge cycle, so it lags the period by one
  assign period = {1'b0, per_cnt_q} + PER_ONE;
  assign onehot = ((period & (period - PER_ONE)) == '0);
  assign dec_ok = onehot && !period[0] && !period[CW];

  always_comb begin
    dec_idx = '0;
    for (int i = 1; i < CW; i++) begin
      if (period[i]) dec_idx = N'(i);
    end
  end

  assign streak_inc = (streak_q >= STREAK_MAX) ? streak_q : streak_q + STREAK_ONE;

  always_comb begin
    state_d    = state_q;
    per_cnt_d  = (&per_cnt_q) ? per_cnt_q : per_cnt_q + CNT_ONE;
    streak_d   = streak_q;
    prescale_d = prescale_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    if (bus.clear) begin
      state_d    = ST_IDLE;
      per_cnt_d  = '0;
      streak_d   = '0;
      prescale_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          per_cnt_d = '0;
          if (rise) state_d = ST_MEASURE;
        end
        ST_MEASURE, ST_LOCKED: begin
          // A saturated counter wins over a coincident edge
          if (&per_cnt_q) begin
            err_d     = 1'b1;
            state_d   = ST_IDLE;
            streak_d  = '0;
            per_cnt_d = '0;
          end else if (rise) begin
            per_cnt_d = '0;
            if (dec_ok) begin
              valid_d    = 1'b1;
              prescale_d = dec_idx;
              streak_d   = (dec_idx == prescale_q) ? streak_inc : STREAK_ONE;
              state_d    = (streak_d >= STREAK_MAX) ? ST_LOCKED : ST_MEASURE;
            end else begin
              err_d    = 1'b1;
              streak_d = '0;
              state_d  = ST_MEASURE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    lock_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      per_cnt_q  <= '0;
      streak_q   <= '0;
      prescale_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      lock_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      streak_q   <= streak_d;
      prescale_q <= prescale_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      lock_q     <= lock_d;
    end
  end

  assign bus.prescale_out = prescale_q;
  assign bus.valid        = valid_q;
  assign bus.err          = err_q;
  assign bus.lock         = lock_q;

endmodule
`default_nettype wire

// File: tb/tb_prescale_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_prescale_detect : table, sequence and random checks vs a model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_prescale_detect;
  localparam int N    = 3;
  localparam int LOCK = 2;
  localparam int MAXP = (1 << N) - 1;
  localparam int TMO  = 1 << (1 << N);

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;

  prescale_detect_if #(.N(N)) bus ();

  prescale_detect #(.N(N), .LOCK_CNT(LOCK)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid, n_err;

  // Reference model: edge timestamps plus a history of decodes (0 = bad)
  int  cyc;
  bit  m_armed;
  int  m_tlast;
  int  m_ps;
  bit  m_prev;
  int  hist[$];

  typedef struct {
    int per;
    int nper;
    int ps;
    bit lk;
    int nv;
    int ne;
  } vec_t;
  vec_t tbl[6];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int decode(int per);
    for (int p = 1; p <= MAXP; p++) if (per == (1 << p)) return p;
    return 0;
  endfunction

  function automatic bit m_lock();
    int sz = hist.size();
    if (sz < LOCK) return 1'b0;
    for (int i = sz - LOCK; i < sz; i++)
      if (hist[i] == 0 || hist[i] != hist[sz-1]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_armed = 1'b0;
    m_tlast = 0;
    m_ps    = 0;
    m_prev  = 1'b0;
    hist.delete();
  endfunction

  task automatic step(input bit d, input bit c);
    int per, p;
    bit e_valid, e_err;
    bus.div_in = d;
    bus.clear  = c;
    @(posedge clk_in);
    #1;
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (c) begin
      m_armed = 1'b0;
      m_ps    = 0;
      hist.delete();
    end else if (m_armed && (cyc - m_tlast) == TMO) begin
      e_err   = 1'b1;
      m_armed = 1'b0;
      hist.push_back(0);
    end else if (d && !m_prev) begin
      if (!m_armed) begin
        m_armed = 1'b1;
        m_tlast = cyc;
      end else begin
        per     = cyc - m_tlast;
        m_tlast = cyc;
        p       = decode(per);
        if (p != 0) begin
          e_valid = 1'b1;
          m_ps    = p;
        end else begin
          e_err = 1'b1;
        end
        hist.push_back(p);
      end
    end
    m_prev = d;
    if (hist.size() > 8) void'(hist.pop_front());
    check("valid", bus.valid, e_valid);
    check("err", bus.err, e_err);
    check("lock", bus.lock, m_lock());
    check("prescale_out", bus.prescale_out, m_ps);
    n_valid += bus.valid;
    n_err   += bus.err;
    cyc++;
  endtask

  task automatic run_wave(input int per, input int nper, input int hi);
    for (int k = 0; k < nper; k++)
      for (int j = 0; j < per; j++) step(j < hi, 1'b0);
  endtask

  task automatic wave_expect(input string name, input int per, input int nper,
                             input int nv, input int ne);
    n_valid = 0;
    n_err   = 0;
    run_wave(per, nper, per / 2);
    check({name, "_nvalid"}, n_valid, nv);
    check({name, "_nerr"}, n_err, ne);
  endtask

  initial begin
    bus.div_in = 1'b0;
    bus.clear  = 1'b0;
    cyc        = 0;
    n_valid    = 0;
    n_err      = 0;
    model_reset();

    tbl[0] = '{8,   5, 3, 1'b1, 4, 0};
    tbl[1] = '{2,   4, 1, 1'b1, 4, 0};
    tbl[2] = '{128, 3, 7, 1'b1, 3, 0};
    tbl[3] = '{12,  4, 7, 1'b0, 1, 3};
    tbl[4] = '{12,  3, 7, 1'b0, 0, 3};
    tbl[5] = '{4,   3, 2, 1'b1, 2, 1};

    repeat (3) @(posedge clk_in);
    #1;
    check("rst_prescale", bus.prescale_out, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_lock", bus.lock, 0);
    check("rst_err", bus.err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      n_valid = 0;
      n_err   = 0;
      run_wave(tbl[i].per, tbl[i].nper, tbl[i].per / 2);
      check("tbl_prescale", bus.prescale_out, tbl[i].ps);
      check("tbl_lock", bus.lock, tbl[i].lk);
      check("tbl_nvalid", n_valid, tbl[i].nv);
      check("tbl_nerr", n_err, tbl[i].ne);
    end

    // Timeout while locked at prescale 2
    n_valid = 0;
    n_err   = 0;
    repeat (300) step(1'b0, 1'b0);
    check("tmo_nerr", n_err, 1);
    check("tmo_nvalid", n_valid, 0);
    check("tmo_prescale", bus.prescale_out, 2);
    check("tmo_lock", bus.lock, 0);
    wave_expect("tmo_arm", 4, 1, 0, 0);
    wave_expect("tmo_relock", 4, 2, 2, 0);
    check("tmo_relock_lock", bus.lock, 1);

    // Clear coincident with a detected edge while locked
    step(1'b1, 1'b1);
    check("clr_lock", bus.lock, 0);
    check("clr_prescale", bus.prescale_out, 0);
    check("clr_valid", bus.valid, 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    wave_expect("clr_arm", 4, 1, 0, 0);
    wave_expect("clr_relock", 4, 2, 2, 0);
    check("clr_relock_lock", bus.lock, 1);
    check("clr_relock_ps", bus.prescale_out, 2);

    // Asynchronous reset in the middle of a period
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_prescale", bus.prescale_out, 0);
    check("arst_valid", bus.valid, 0);
    check("arst_lock", bus.lock, 0);
    check("arst_err", bus.err, 0);
    model_reset();
    bus.div_in = 1'b0;
    @(posedge clk_in);
    #1;
    rst_n = 1'b1;
    wave_expect("arst_first", 8, 1, 0, 0);
    wave_expect("arst_decode", 8, 2, 2, 0);
    check("arst_lock_after", bus.lock, 1);
    check("arst_ps_after", bus.prescale_out, 3);

    // Randomised segments with sporadic clear and long idle gaps
    for (int s = 0; s < 60; s++) begin
      int per, nper, hi;
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(200, 300)) step(1'b0, 1'b0);
      end else begin
        if ($urandom_range(0, 1) == 1) per = 1 << $urandom_range(1, MAXP);
        else per = $urandom_range(2, 140);
        nper = $urandom_range(1, 4);
        hi   = $urandom_range(1, per - 1);
        for (int k = 0; k < nper; k++)
          for (int j = 0; j < per; j++)
            step(j < hi, $urandom_range(0, 99) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prescale_detect.md
# prescale_detect

- Recovers the prescale setting of a divided clock: measures the period of a free-running divided clock in `clk_in` cycles and decodes it back to the prescale index that produced it.
- Sits at the receiving end of a prescaler output, for example a clock crossing a board, a debug pin or a peripheral. Used for self-check and rate auto-detection.
- Reports the decoded index, a per-measurement valid pulse, a lock flag and an error pulse.

## Interface
- `N`, default 3: prescale index width. Legal indices are 1..2^N-1, giving period 2^p cycles.
- `LOCK_CNT`, default 2: number of consecutive identical decodes required to assert `lock`.
- `clk_in`, in, 1: system clock. All logic is in this single clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `div_in`, in, 1: divided clock under measurement. It may be asynchronous to `clk_in`.
- `clear`, in, 1: synchronous restart of measurement.
- `prescale_out`, out, N: last decoded prescale index.
- `valid`, out, 1: one-cycle pulse when `prescale_out` is updated.
- `lock`, out, 1: level. High while `LOCK_CNT` or more consecutive decodes are identical.
- `err`, out, 1: one-cycle pulse on a non-power-of-two period or a timeout.

## Operation
- Period counter `per_cnt` is 2^N bits wide and saturates at all-ones.
- Rising edges of the sampled `div_in` are detected in `clk_in`. Period is the number of `clk_in` cycles between two consecutive detected rising edges. Legal range is 2..2^(2^N-1).
- **Decode:**
  - Period equal to 2^p with 1 ≤ p ≤ 2^N-1: result is p.
  - Any other period, including 1: raise the `err` pulse and set streak to 0.
- **States:**
  - IDLE: waits for the first rising edge. On that edge, clear `per_cnt` and go to MEASURE.
  - MEASURE: on each edge, decode. If the decode is valid and equal to the previous decode, increment streak (saturating at `LOCK_CNT`). Otherwise set streak to 1. When streak reaches `LOCK_CNT`, go to LOCKED.
  - LOCKED: a valid decode equal to `prescale_out` keeps lock. A differing valid decode sets streak to 1 and returns to MEASURE. An invalid decode sets streak to 0 and returns to MEASURE.
- **Timeout:** if `per_cnt` saturates in MEASURE or LOCKED, raise `err` for one cycle and go to IDLE. `prescale_out` holds its value.
- **`clear`:** takes priority over a simultaneous edge. Go to IDLE, set streak to 0, `lock` to 0 and `prescale_out` to 0. No `valid` or `err` is raised in that cycle.
- **Reset values:** `prescale_out`=0, `valid`=0, `lock`=0, `err`=0, state IDLE, `per_cnt`=0.
- Reset asserted mid-measurement discards the partial period. The first period after reset is not decoded.

## Timing
- Edge-to-detect latency: 2 `clk_in` cycles with the synchronizer compiled in, 0 without.
- `valid` and `err` are registered. They pulse in the cycle after the detecting edge.
- `prescale_out` changes in the same cycle as `valid` is high. It is stable at all other times.
- `lock` rises in the cycle `valid` reports the `LOCK_CNT`-th identical decode. It falls in the cycle `valid` or `err` reports the mismatch.
- Minimum decodable period is 2 cycles, i.e. `div_in` toggling every `clk_in` cycle.

## Configuration
- `PRESCALE_DETECT_SYNC_EN`:
  - Defined: `div_in` passes through a 2-flop synchronizer before edge detection. Required for asynchronous sources.
  - Undefined: `div_in` is sampled by the edge register directly. Only for sources generated in the `clk_in` domain. Latency drops by 2 cycles; periods are unchanged.

## Structure
- Shared package `prescale_pkg`: the state type (IDLE, MEASURE, LOCKED) and the default `LOCK_CNT`.
- Sub-module `sync_edge`: optional 2-flop synchronizer plus rising-edge pulse generator, honouring `PRESCALE_DETECT_SYNC_EN`.
- The top level holds `per_cnt`, the decoder (one-hot check plus priority encoder), the streak counter and the state machine.

## Test plan
- `div_in` from a prescaler with prescale=3, driven from `clk_in` → `valid` every 8 cycles, `prescale_out`=3, `lock`=1 at the 2nd `valid`, no `err`.
- Prescale=1 (period 2) → `prescale_out`=1 and `lock`; then switch to prescale=7 (period 128) → `lock` drops, relocks with `prescale_out`=7 after 2 periods.
- Period 12 cycles → `err` pulse per period, `lock`=0, `valid` never asserted.
- Hold `div_in` low while locked at prescale=2 → `err` pulse after `per_cnt` saturates, state IDLE, `prescale_out` stays 2, `lock`=0.
- Assert `clear` in the same cycle as a detected edge while locked → `lock`=0, `prescale_out`=0, no `valid`; relock after 1 discarded edge plus 2 periods.
- Assert `rst_n` low mid-period → all outputs 0 immediately; after release, the first decode appears only after two full periods.
